// File: rtl/iterative_divider.sv
// Unsigned multi-cycle restoring divider.
// One quotient bit is resolved per clock through a WIDTH+1 bit subtract/borrow step.
// A valid/ready handshake on each side allows one operation in flight at a time.
module iterative_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Count value seen during the final (WIDTH-th) iteration.
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic             dbz_reg;

  logic             accept;
  logic             zero_div;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH:0]   diff;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid & in_ready;
  assign zero_div    = (divisor == '0);
  assign quotient    = q_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

  // One restoring step: shift in the next dividend bit, then trial-subtract the divisor.
  always_comb begin
    r_shift = {rem_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    diff    = {1'b0, r_shift} - {1'b0, dsr_reg};
  end

  // Control FSM and iteration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count <= '0;
            state <= zero_div ? DONE : RUN;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operand capture on accept, one quotient bit per RUN cycle, frozen otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg   <= '0;
      rem_reg <= '0;
      dsr_reg <= '0;
      dbz_reg <= 1'b0;
    end else begin
      if (accept) begin
        dsr_reg <= divisor;
        if (zero_div) begin
          // Division by zero short-circuits straight to the result.
          q_reg   <= '1;
          rem_reg <= dividend;
          dbz_reg <= 1'b1;
        end else begin
          q_reg   <= dividend;
          rem_reg <= '0;
          dbz_reg <= 1'b0;
        end
      end else if (state == RUN) begin
        // A borrow in the top bit means the divisor did not fit: keep the shifted remainder.
        q_reg   <= {q_reg[WIDTH-2:0], ~diff[WIDTH]};
        rem_reg <= diff[WIDTH] ? r_shift : diff[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed table, hand-written
// reset/backpressure sequences and randomized operations against a
// plain-arithmetic reference model.
module tb_iterative_divider;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int compared;
  int mismatched;

  iterative_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           hold;
    bit           pulse;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the arithmetic definition of the result, including the zero-divisor rule.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dbz);
    if (b == '0) begin
      q   = '1;
      r   = a;
      dbz = 1'b1;
    end else begin
      q   = a / b;
      r   = a % b;
      dbz = 1'b0;
    end
  endfunction

  // Issue one request (entered #1 after a rising edge) and check latency, result,
  // stability under backpressure and the return to idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                        input int hold, input bit pulse, input string tag);
    int  n;
    bit  got;
    int  exp_lat;
    exp_lat = (b == '0) ? 1 : W;
    chk({tag, " in_ready_idle"}, W'(in_ready), W'(1));
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    n   = 0;
    got = 0;
    while (n < 200 && !got) begin
      @(posedge clk); #1;
      n++;
      if (pulse && n == 3) begin
        in_valid = 1'b1;
        divisor  = '0;
      end
      if (!got && n >= 2 && !out_valid && in_ready) begin
        chk({tag, " busy_in_ready"}, W'(in_ready), W'(0));
      end
      if (out_valid) got = 1;
    end
    if (!got) begin
      chk({tag, " out_valid_timeout"}, W'(0), W'(1));
      in_valid = 1'b0;
      return;
    end
    chk({tag, " latency"}, W'(n), W'(exp_lat));
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, W'(div_by_zero), W'(edbz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold_out_valid"}, W'(out_valid), W'(1));
      chk({tag, " hold_quotient"}, quotient, eq);
      chk({tag, " hold_remainder"}, remainder, er);
      chk({tag, " hold_in_ready"}, W'(in_ready), W'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid_after_hs"}, W'(out_valid), W'(0));
    chk({tag, " in_ready_after_hs"}, W'(in_ready), W'(1));
    $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0d", tag, a, b, quotient, remainder, div_by_zero);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rq, rr;
    logic         rdbz;

    compared   = 0;
    mismatched = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    vecs[0] = '{64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 0, 1'b0};
    vecs[1] = '{64'd1000000, 64'd1000000, 64'd1, 64'd0, 1'b0, 0, 1'b0};
    vecs[2] = '{64'd123456789, 64'd987654321, 64'd0, 64'd123456789, 1'b0, 0, 1'b0};
    vecs[3] = '{64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, 0, 1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 0, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 0, 1'b0};
    vecs[6] = '{64'd1000, 64'd3, 64'd333, 64'd1, 1'b0, 10, 1'b1};
    vecs[7] = '{64'd0, 64'd9, 64'd0, 64'd0, 1'b0, 2, 1'b0};

    // Reset state while reset is held.
    #2;
    chk("reset in_ready", W'(in_ready), W'(1));
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset quotient", quotient, '0);
    chk("reset remainder", remainder, '0);
    chk("reset div_by_zero", W'(div_by_zero), W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz,
             vecs[i].hold, vecs[i].pulse, $sformatf("vec%0d", i));
    end

    // Reset in the middle of 1000/3, at iteration 30.
    dividend = 64'd1000;
    divisor  = 64'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst in_ready", W'(in_ready), W'(1));
    chk("midrst out_valid", W'(out_valid), W'(0));
    chk("midrst quotient", quotient, '0);
    chk("midrst remainder", remainder, '0);
    chk("midrst div_by_zero", W'(div_by_zero), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) chk("midrst no_result", W'(out_valid), W'(0));
    end
    $display("op midrst: reset during 1000/3 at iteration 30");
    run_op(64'd1000, 64'd3, 64'd333, 64'd1, 1'b0, 0, 1'b0, "after_rst");

    // Randomized operations against the reference model.
    for (int k = 0; k < 1000; k++) begin
      ra = {$urandom, $urandom} >> $urandom_range(0, 63);
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) rb = '0;
      ref_div(ra, rb, rq, rr, rdbz);
      run_op(ra, rb, rq, rr, rdbz, $urandom_range(0, 2), 1'b0, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
